// File: rtl/dcache_controller_if.sv
// CPU-side, comparator and main-memory signals of the direct-mapped data cache.
// The slave modport is the cache; the master modport is its environment.
interface dcache_controller_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic [2:0]  tag_stored;
  logic [2:0]  tag_in;
  logic        tag_check;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  read, write, address, writedata, tag_check, mem_readdata, mem_busywait,
    output readdata, busywait, tag_stored, tag_in, mem_read, mem_write,
           mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, tag_check, mem_readdata, mem_busywait,
    input  readdata, busywait, tag_stored, tag_in, mem_read, mem_write,
           mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: 8 lines x 4 bytes, hits in zero added cycles,
// misses stall the CPU via busywait through WRITEBACK/FETCH/UPDATE until the line is refilled.
module dcache_controller (
  input  logic          clock,
  input  logic          reset,
  dcache_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [31:0] fetch_q, fetch_d;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  logic [2:0]  tag_v;
  logic [2:0]  idx;
  logic [1:0]  off;
  logic        hit;
  logic [31:0] blk_cur;
  logic [31:0] blk_merged;
  logic        line_we;
  logic [31:0] line_data_d;
  logic [2:0]  line_tag_d;

  assign tag_v   = bus.address[7:5];
  assign idx     = bus.address[4:2];
  assign off     = bus.address[1:0];
  assign blk_cur = data_q[idx];
  assign hit     = valid_q[idx] & bus.tag_check;

  assign bus.tag_stored = tag_q[idx];
  assign bus.tag_in     = tag_v;
  assign bus.readdata   = hit ? blk_cur[{off, 3'b000} +: 8] : 8'h00;

  always_comb begin
    blk_merged = blk_cur;
    blk_merged[{off, 3'b000} +: 8] = bus.writedata;
  end

  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    dirty_d           = dirty_q;
    fetch_d           = fetch_q;
    line_we           = 1'b0;
    line_data_d       = blk_merged;
    line_tag_d        = tag_q[idx];
    bus.busywait      = 1'b1;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = {tag_v, idx};
    bus.mem_writedata = blk_cur;

    unique case (state_q)
      IDLE: begin
        bus.busywait = (bus.read | bus.write) & ~hit;
        // A simultaneous read and write is served as a write.
        if (bus.write && hit) begin
          line_we      = 1'b1;
          dirty_d[idx] = 1'b1;
        end else if ((bus.read || bus.write) && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        bus.mem_write   = 1'b1;
        bus.mem_address = {tag_q[idx], idx};
        if (!bus.mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        bus.mem_read = 1'b1;
        if (!bus.mem_busywait) begin
          fetch_d = bus.mem_readdata;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        line_we      = 1'b1;
        line_data_d  = fetch_q;
        line_tag_d   = tag_v;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      fetch_q <= fetch_d;
    end
  end

  // Tag/data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clock) begin
    if (!reset && line_we) begin
      data_q[idx] <= line_data_d;
      tag_q[idx]  <= line_tag_d;
    end
  end

endmodule
